// File: rtl/ulight_fifo_flag_pio_rx.sv
// ulight_fifo_flag_pio_rx
// Avalon-MM slave input port exposing the uLight SpaceWire RX-FIFO status
// flags, with optional input synchroniser, per-bit sticky edge capture,
// interrupt mask and level interrupt output.
//
// Build option: define ULIGHT_FIFO_FLAG_SYNC_EN to insert a SYNC_STAGES-deep
// flop chain on in_port (asynchronous flag sources). Undefined: in_port is
// used directly and must be synchronous to clk.
//
// Ports:
//   clk         single clock
//   reset_n     asynchronous active-low reset
//   address     register select (0 DATA, 1 MASK, 2 reserved, 3 EDGE W1C)
//   chipselect  slave select, qualifies writes
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     raw flag inputs
//   readdata    registered read data (1-cycle latency, zero-extended)
//   irq         level interrupt, |(edge_cap & irq_mask)
module ulight_fifo_flag_pio_rx #(
  parameter int unsigned WIDTH       = 9,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Elaboration-time parameter range checks
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("WIDTH out of range");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end
  if (EDGE_TYPE > 2) begin : g_bad_edge
    $error("EDGE_TYPE out of range");
  end

  logic [WIDTH-1:0] s_in;
  logic [WIDTH-1:0] s_prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_det_c;
  logic [WIDTH-1:0] wdata_c;
  logic [WIDTH-1:0] edge_clr_c;
  logic [31:0]      rd_data_c;
  logic             wr_en_c;

`ifdef ULIGHT_FIFO_FLAG_SYNC_EN
  // Synchroniser chain; last stage is the clean flag value
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s_in = sync_q[SYNC_STAGES-1];
`else
  assign s_in = in_port;
`endif

  // Upper write-data bits are don't-care for every register
  if (WIDTH < 32) begin : g_wdata_unused
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  assign wr_en_c    = chipselect && !write_n;
  assign wdata_c    = writedata[WIDTH-1:0];
  assign edge_clr_c = (wr_en_c && address == ADDR_EDGE) ? wdata_c : '0;

  // Per-bit edge detector selected by EDGE_TYPE
  always_comb begin
    edge_det_c = '0;
    case (EDGE_TYPE)
      0:       edge_det_c = s_in & ~s_prev;
      1:       edge_det_c = ~s_in & s_prev;
      default: edge_det_c = s_in ^ s_prev;
    endcase
  end

  // Previous-value register and mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_prev   <= '0;
      irq_mask <= '0;
    end else begin
      s_prev <= s_in;
      if (wr_en_c && address == ADDR_MASK) irq_mask <= wdata_c;
    end
  end

  // Sticky capture: a new edge overrides a simultaneous W1C clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_cap <= '0;
    else          edge_cap <= (edge_cap & ~edge_clr_c) | edge_det_c;
  end

  // Read mux, sampled every cycle regardless of chipselect
  always_comb begin
    rd_data_c = '0;
    case (address)
      ADDR_DATA: rd_data_c = 32'(s_in);
      ADDR_MASK: rd_data_c = 32'(irq_mask);
      ADDR_EDGE: rd_data_c = 32'(edge_cap);
      default:   rd_data_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_data_c;
  end

  // Driven only from registers, so no combinational input glitches reach irq
  assign irq = |(edge_cap & irq_mask);

endmodule
